nes_joypad_ports: RTL
=====================

Name: nes_joypad_ports

Overview:
- Multi-player NES controller-port emulator. Generalises the single inline 8-bit joypad shift register in the top level.
- Sits between button sources (onboard BTN, USB HID decoder, external pads) and the NES core's strobe/clock/data joypad pins.
- Adds per-port shift registers, per-port read clocks, autofire on A/B, opposite-direction blocking, and per-port external-pad passthrough.

Parameters:
- C_players, 2, number of controller ports (1..4).
- C_clk_hz, 21477272, frequency of clk in Hz.
- C_autofire_hz, 10, autofire toggle rate (full on/off cycles per second).
- C_block_opposite, 1, 1: up+down or left+right pressed together reads as neither pressed.
- C_fill_bit, 1, value shifted in after the 8 button bits are consumed (official pad returns 1).

Ports:
- clk  in  1  NES core clock.
- resetn  in  1  asynchronous active-low reset.
- i_strobe  in  1  joypad strobe/latch from the NES core, level sensitive.
- i_joy_clock  in  C_players  per-port read clock from the NES core; the shift happens on the falling edge.
- i_btn  in  8*C_players  button state, port p at [8p+7:8p], 1 = pressed. Bit order 0..7: A, B, select, start, up, down, left, right. Asynchronous.
- i_autofire_en  in  2*C_players  port p at [2p+1:2p]; bit0 enables autofire on A, bit1 on B.
- i_ext_mode  in  C_players  1 selects external pad passthrough for the port.
- i_ext_data  in  C_players  raw serial data from an external pad, active-low.
- o_data  out  C_players  serial data to the NES core, 1 = pressed.
- o_autofire_phase  out  1  current autofire gate, for debug and LED.

Behaviour:
- Reset (resetn=0, asynchronous):
  - o_data = 0 and o_autofire_phase = 0.
  - Shift registers, synchronisers and edge-detect registers cleared to 0; autofire counter = 0.
- Synchronisation:
  - i_btn, i_ext_data and i_ext_mode each pass through a 2-FF synchroniser.
  - i_strobe and i_joy_clock are already in the clk domain: register once for edge detection only.
- Autofire:
  - Half period H = C_clk_hz/(2*C_autofire_hz) cycles; the counter runs 0..H-1.
  - At H-1 the counter wraps to 0 and o_autofire_phase toggles.
  - Counter width is clog2(H).
- Effective buttons, per port:
  - A_eff = A & (~af_en[0] | phase); B_eff likewise with af_en[1].
  - If C_block_opposite=1: up=1 and down=1 gives both 0; left=1 and right=1 gives both 0.
  - The effective value is computed combinationally from the synchronised buttons.
- Shift register, per port (8 bits):
  - Load: every cycle i_strobe=1, load the effective buttons.
  - Shift: when i_strobe=0 and a falling edge of i_joy_clock[p] is detected (prev=1, cur=0), shift right and insert C_fill_bit at bit 7.
  - After 8 shifts, reads return C_fill_bit indefinitely until the next strobe.
  - If a falling edge coincides with strobe=1, the load wins and no shift occurs.
  - Falling edges on one port never affect the other ports.
- Output:
  - o_data[p] is registered: shift_reg[p][0] when i_ext_mode[p]=0, else ~ext_data_sync[p].
  - Latency: a load or shift is visible on o_data 1 cycle after the clk edge at which it happens.
  - The edge is detected 1 cycle after the i_joy_clock fall, so total latency from the fall is 2 cycles.
- Mode switch: a change of i_ext_mode mid-read takes effect on o_data immediately (after sync); the internal shift register continues independently.
- Reset mid-read: state is discarded. The first read after reset release requires a strobe; without one, reads return 0 (the cleared register) and then fill bits.

Test Plan:
- Single pad, port 0, all features off: i_btn[7:0]=8'b1001_0001 (right, up, A); strobe 1→0; 9 falling edges of i_joy_clock[0] -> o_data sequence 1,0,0,0,1,0,0,1 then 1 (fill). Port 1 stays at its loaded bit 0 throughout.
- Independent ports: port0 btn=8'h01, port1 btn=8'h02; strobe; one falling edge on port1 only -> o_data[1] goes 0→1 two cycles after the edge; o_data[0] stays 1.
- Opposite blocking: btn=8'b0011_0000 (up+down) with C_block_opposite=1 -> bits 4 and 5 read 0. With C_block_opposite=0 -> both read 1.
- Autofire (bench C_clk_hz=1000, C_autofire_hz=10, so H=50): A held, af_en=2'b01; strobe every 10 cycles -> latched A alternates between 50-cycle runs of 0 and 1; o_autofire_phase toggles every 50 cycles.
- Strobe/clock collision: a falling edge on i_joy_clock coincides with strobe=1 -> the register equals the freshly loaded buttons and bit0 is not consumed.
- Async reset mid-read: after 3 shifts, pulse resetn low for 1 ns -> o_data=0 immediately. After release and a new strobe, the full 8-bit sequence repeats correctly. Separately, i_ext_mode[0]=1 with i_ext_data[0]=0 -> o_data[0]=1 three cycles later.

Source files
------------

// File: rtl/nes_joypad_ports.sv
// Multi-port NES joypad emulator: per-port 8-bit shift registers, autofire, opposite-direction blocking, external pad passthrough.
// o_data is registered, one cycle after a load or shift; there is no backpressure, and reads simply follow the core's strobe and clock pins.
module nes_joypad_ports #(
  parameter int C_players        = 2,
  parameter int C_clk_hz         = 21477272,
  parameter int C_autofire_hz    = 10,
  parameter int C_block_opposite = 1,
  parameter int C_fill_bit       = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_strobe,
  input  logic [C_players-1:0]   i_joy_clock,
  input  logic [8*C_players-1:0] i_btn,
  input  logic [2*C_players-1:0] i_autofire_en,
  input  logic [C_players-1:0]   i_ext_mode,
  input  logic [C_players-1:0]   i_ext_data,
  output logic [C_players-1:0]   o_data,
  output logic                   o_autofire_phase
);

  localparam int C_half  = C_clk_hz / (2 * C_autofire_hz);
  localparam int C_cnt_w = (C_half > 1) ? $clog2(C_half) : 1;
  localparam logic [C_cnt_w-1:0] C_half_last = C_cnt_w'(C_half - 1);
  localparam logic C_fill = 1'(C_fill_bit);
  localparam logic C_block = (C_block_opposite != 0);

  logic [8*C_players-1:0] btn_s1, btn_s2;
  logic [C_players-1:0]   ext_data_s1, ext_data_s2;
  logic [C_players-1:0]   ext_mode_s1, ext_mode_s2;
  logic [C_players-1:0]   joy_clock_cur, joy_clock_prev;
  logic [C_cnt_w-1:0]     af_cnt;
  logic [7:0]             shift_reg [C_players];
  logic [7:0]             btn_eff   [C_players];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1         <= '0;
      btn_s2         <= '0;
      ext_data_s1    <= '0;
      ext_data_s2    <= '0;
      ext_mode_s1    <= '0;
      ext_mode_s2    <= '0;
      joy_clock_cur  <= '0;
      joy_clock_prev <= '0;
    end else begin
      btn_s1         <= i_btn;
      btn_s2         <= btn_s1;
      ext_data_s1    <= i_ext_data;
      ext_data_s2    <= ext_data_s1;
      ext_mode_s1    <= i_ext_mode;
      ext_mode_s2    <= ext_mode_s1;
      joy_clock_cur  <= i_joy_clock;
      joy_clock_prev <= joy_clock_cur;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      af_cnt           <= '0;
      o_autofire_phase <= 1'b0;
    end else if (af_cnt == C_half_last) begin
      af_cnt           <= '0;
      o_autofire_phase <= ~o_autofire_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  // Autofire gates A/B with the phase; pressing both ends of an axis reads as neither.
  always_comb begin
    for (int p = 0; p < C_players; p++) begin
      btn_eff[p]    = btn_s2[8*p +: 8];
      btn_eff[p][0] = btn_s2[8*p]     & (~i_autofire_en[2*p]     | o_autofire_phase);
      btn_eff[p][1] = btn_s2[8*p + 1] & (~i_autofire_en[2*p + 1] | o_autofire_phase);
      if (C_block && btn_s2[8*p + 4] && btn_s2[8*p + 5]) begin
        btn_eff[p][5:4] = 2'b00;
      end
      if (C_block && btn_s2[8*p + 6] && btn_s2[8*p + 7]) begin
        btn_eff[p][7:6] = 2'b00;
      end
    end
  end

  // Strobe has priority: a falling read clock during strobe is not a shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < C_players; p++) begin
        shift_reg[p] <= 8'h00;
      end
    end else begin
      for (int p = 0; p < C_players; p++) begin
        if (i_strobe) begin
          shift_reg[p] <= btn_eff[p];
        end else if (joy_clock_prev[p] && !joy_clock_cur[p]) begin
          shift_reg[p] <= {C_fill, shift_reg[p][7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_data <= '0;
    end else begin
      for (int p = 0; p < C_players; p++) begin
        o_data[p] <= ext_mode_s2[p] ? ~ext_data_s2[p] : shift_reg[p][0];
      end
    end
  end

endmodule
